fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencing controller for the PC register and the IF stage of the 3-stage MIPS150 pipeline (IF / EX / MEM-WB).
- Each cycle it decides between the 2-bit PC select code and the PC enable.
- It freezes or bubbles the pipeline on memory stalls and load-use hazards.
- It holds the fetch idle through a post-reset boot window, and keeps stall and redirect performance counters.

Parameters:
BOOT_CYCLES, 2, number of cycles after reset release during which the PC is held at the reset vector and fetch output is bubbled (legal range 1..15).
CNT_W, 32, width of the performance counters.

Ports:
CLK  input  1  clock; all state updates on posedge.
RST  input  1  synchronous, active-high reset.
Branch_Taken  input  1  EX-stage conditional branch resolved taken.
Jump  input  1  EX-stage J/JAL.
Jump_Reg  input  1  EX-stage JR/JALR.
Load_Use  input  1  decode hazard: the instruction in IF needs a load result not yet available.
IC_Stall  input  1  instruction cache miss in progress.
DC_Stall  input  1  data cache miss in progress.
PC_Sel  output  2  select code to PC: 2'b10 = PC+4, 2'b01 = branch target, 2'b11 = jump target, 2'b00 = register target.
PC_EN  output  1  PC register load enable.
Pipe_EN  output  1  enable for IF/EX and EX/WB pipeline registers.
IF_Bubble  output  1  replace the IF/EX register contents with a NOP on this edge.
Booting  output  1  high while in the BOOT state.
Stall_Cnt  output  CNT_W  count of cycles with PC_EN = 0 outside BOOT.
Redir_Cnt  output  CNT_W  count of applied redirects.

Behaviour:
- Outputs are combinational from the state and current inputs; the state, boot counter and performance counters are registered.
- RST wins over everything on the same edge. This includes RST asserted mid-stall: the stall is abandoned and there is no replay.
- Reset values and outputs while RST is high:
  - state = BOOT, boot counter = BOOT_CYCLES-1, Stall_Cnt = Redir_Cnt = 0.
  - PC_Sel = 2'b10, PC_EN = 0, Pipe_EN = 0, IF_Bubble = 1, Booting = 1.
- Redirect code priority (EX holds exactly one instruction; more than one flag high is an upstream bug): Jump_Reg -> 2'b00; Jump -> 2'b11; Branch_Taken -> 2'b01; none -> 2'b10.
- Architectural branch delay slot: a redirect never bubbles or flushes IF.
- States:
  - BOOT:
    - PC_EN = 0, Pipe_EN = 1, IF_Bubble = 1, PC_Sel = 2'b10. Redirect and hazard inputs are ignored.
    - The boot counter decrements each cycle. When it reaches 0, go to RUN on the next edge.
    - The first PC update occurs on the first RUN edge.
  - RUN:
    - If DC_Stall or IC_Stall: PC_EN = 0, Pipe_EN = 0, IF_Bubble = 0. Go to MSTALL. The redirect is not applied.
    - Else if Load_Use: PC_EN = 0, Pipe_EN = 1, IF_Bubble = 1, PC_Sel = 2'b10. Go to LU. A simultaneous redirect is illegal (EX holds the load) and is ignored.
    - Else: PC_EN = 1, Pipe_EN = 1, IF_Bubble = 0, PC_Sel = redirect code. Stay in RUN.
  - MSTALL:
    - Whole pipe frozen: PC_EN = 0, Pipe_EN = 0, IF_Bubble = 0. The EX instruction stays stable, so redirect inputs are re-evaluated on exit.
    - When both stalls are low, that same cycle behaves exactly as RUN, including redirect, Load_Use and the next state.
  - LU:
    - Exactly one cycle. Behaves as RUN, except that a second consecutive Load_Use is honoured (stay in LU).
- Counters:
  - Stall_Cnt increments in every non-BOOT cycle with PC_EN = 0.
  - Redir_Cnt increments in every cycle with PC_EN = 1 and PC_Sel != 2'b10.
  - Both wrap modulo 2^CNT_W with no saturation.
- Simultaneous DC_Stall and IC_Stall: treated as a single MSTALL. Exit only when both are low.

Test Plan:
- Reset then boot, BOOT_CYCLES = 2 → PC_EN = 0 and IF_Bubble = 1 for 2 cycles after RST falls; the third cycle has PC_EN = 1, PC_Sel = 2'b10, Booting = 0.
- Branch_Taken pulse in RUN → same cycle PC_Sel = 2'b01, PC_EN = 1, IF_Bubble = 0; Redir_Cnt 0 → 1. Repeat with Jump (2'b11) and Jump_Reg (2'b00).
- DC_Stall held 5 cycles while Jump is high → PC_EN = 0 and Pipe_EN = 0 for 5 cycles; on the release cycle PC_Sel = 2'b11 and PC_EN = 1; Stall_Cnt = 5, Redir_Cnt = 1.
- Load_Use for 1 cycle, then 2 back-to-back → 1 and 2 bubble cycles with PC_EN = 0 and Pipe_EN = 1; Stall_Cnt = 3.
- RST asserted in the 3rd cycle of a 10-cycle IC_Stall → next cycle state BOOT, counters 0, PC_EN = 0. After the boot window, IC_Stall still high → MSTALL.
- Counter wrap with CNT_W = 4: 17 stall cycles → Stall_Cnt = 1.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Brief    : PC / IF-stage sequencing controller for the 3-stage MIPS150
//             pipeline. Chooses the PC select code and the PC enable, freezes
//             the pipe on cache misses, bubbles IF on load-use hazards, holds
//             fetch idle through a post-reset boot window, and keeps stall and
//             redirect performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 2,   // boot window length, 1..15
  parameter int CNT_W       = 32   // performance counter width
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Branch_Taken,
  input  logic             Jump,
  input  logic             Jump_Reg,
  input  logic             Load_Use,
  input  logic             IC_Stall,
  input  logic             DC_Stall,
  output logic [1:0]       PC_Sel,
  output logic             PC_EN,
  output logic             Pipe_EN,
  output logic             IF_Bubble,
  output logic             Booting,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Redir_Cnt
);

  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JMP  = 2'b11;
  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_MSTALL = 2'd2,
    S_LU     = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] boot_cnt;
  logic [1:0] redir_code;
  logic       mem_stall;

  // Redirect code from the single EX instruction; register jumps take priority.
  always_comb begin
    redir_code = SEL_PC4;
    if (Jump_Reg)          redir_code = SEL_REG;
    else if (Jump)         redir_code = SEL_JMP;
    else if (Branch_Taken) redir_code = SEL_BR;
  end

  assign mem_stall = IC_Stall | DC_Stall;

  // Output decode and next-state. MSTALL and LU re-run the RUN decision every
  // cycle, so a released stall or a finished bubble acts exactly like RUN.
  always_comb begin
    PC_Sel    = SEL_PC4;
    PC_EN     = 1'b0;
    Pipe_EN   = 1'b0;
    IF_Bubble = 1'b1;
    Booting   = 1'b0;
    state_nxt = state;
    if (RST) begin
      Booting   = 1'b1;
      state_nxt = S_BOOT;
    end else begin
      case (state)
        S_BOOT: begin
          Pipe_EN   = 1'b1;
          IF_Bubble = 1'b1;
          Booting   = 1'b1;
          state_nxt = (boot_cnt == 4'd0) ? S_RUN : S_BOOT;
        end
        default: begin
          if (mem_stall) begin
            // Whole pipe frozen; the EX redirect is re-evaluated on release.
            Pipe_EN   = 1'b0;
            IF_Bubble = 1'b0;
            state_nxt = S_MSTALL;
          end else if (Load_Use) begin
            // EX holds the load, so any redirect flag here is ignored.
            Pipe_EN   = 1'b1;
            IF_Bubble = 1'b1;
            state_nxt = S_LU;
          end else begin
            // Delay slot is architectural: redirects never bubble IF.
            PC_EN     = 1'b1;
            Pipe_EN   = 1'b1;
            IF_Bubble = 1'b0;
            PC_Sel    = redir_code;
            state_nxt = S_RUN;
          end
        end
      endcase
    end
  end

  // State, boot countdown and wrapping performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_BOOT;
      boot_cnt  <= BOOT_INIT;
      Stall_Cnt <= '0;
      Redir_Cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_BOOT && boot_cnt != 4'd0)
        boot_cnt <= boot_cnt - 4'd1;
      if (state != S_BOOT && !PC_EN)
        Stall_Cnt <= Stall_Cnt + CNT_ONE;
      if (PC_EN && PC_Sel != SEL_PC4)
        Redir_Cnt <= Redir_Cnt + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Brief    : Self-checking bench for fetch_ctrl. A cycle-level reference
//             model (boot cycles remaining plus per-cycle decision rules)
//             predicts every output; directed scenarios are followed by a
//             randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MOD     = 1 << CNT_W;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             Branch_Taken = 1'b0;
  logic             Jump = 1'b0;
  logic             Jump_Reg = 1'b0;
  logic             Load_Use = 1'b0;
  logic             IC_Stall = 1'b0;
  logic             DC_Stall = 1'b0;
  logic [1:0]       PC_Sel;
  logic             PC_EN;
  logic             Pipe_EN;
  logic             IF_Bubble;
  logic             Booting;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Redir_Cnt;

  fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .Branch_Taken(Branch_Taken), .Jump(Jump), .Jump_Reg(Jump_Reg),
    .Load_Use(Load_Use), .IC_Stall(IC_Stall), .DC_Stall(DC_Stall),
    .PC_Sel(PC_Sel), .PC_EN(PC_EN), .Pipe_EN(Pipe_EN),
    .IF_Bubble(IF_Bubble), .Booting(Booting),
    .Stall_Cnt(Stall_Cnt), .Redir_Cnt(Redir_Cnt)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state: boot cycles left, counter values.
  int m_boot  = BOOT_CYCLES;
  int m_stall = 0;
  int m_redir = 0;

  // Last sampled DUT values, for directed spot checks.
  logic [1:0]       s_sel;
  logic             s_pc, s_pipe, s_bub, s_boot;
  logic [CNT_W-1:0] s_stall, s_redir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic bt, input logic j, input logic jr,
                        input logic lu, input logic ic, input logic dc);
    RST = rst; Branch_Taken = bt; Jump = j; Jump_Reg = jr;
    Load_Use = lu; IC_Stall = ic; DC_Stall = dc;
  endtask

  // One clock: predict, sample at negedge, compare, advance the model.
  task automatic cycle();
    logic [1:0] e_sel;
    logic       e_pc, e_pipe, e_bub, e_boot, sel_known;
    @(negedge CLK);
    sel_known = 1'b1;
    e_sel = 2'b10; e_pc = 1'b0; e_pipe = 1'b0; e_bub = 1'b1; e_boot = 1'b0;
    if (RST) begin
      e_boot = 1'b1;
    end else if (m_boot > 0) begin
      e_pipe = 1'b1; e_boot = 1'b1;
    end else if (IC_Stall || DC_Stall) begin
      e_bub = 1'b0; sel_known = 1'b0;
    end else if (Load_Use) begin
      e_pipe = 1'b1;
    end else begin
      e_pc = 1'b1; e_pipe = 1'b1; e_bub = 1'b0;
      e_sel = Jump_Reg ? 2'b00 : Jump ? 2'b11 : Branch_Taken ? 2'b01 : 2'b10;
    end
    s_sel = PC_Sel; s_pc = PC_EN; s_pipe = Pipe_EN; s_bub = IF_Bubble;
    s_boot = Booting; s_stall = Stall_Cnt; s_redir = Redir_Cnt;
    if (sel_known) chk("pc_sel", 32'(PC_Sel), 32'(e_sel));
    chk("pc_en",     32'(PC_EN),     32'(e_pc));
    chk("pipe_en",   32'(Pipe_EN),   32'(e_pipe));
    chk("if_bubble", 32'(IF_Bubble), 32'(e_bub));
    chk("booting",   32'(Booting),   32'(e_boot));
    chk("stall_cnt", 32'(Stall_Cnt), 32'(m_stall));
    chk("redir_cnt", 32'(Redir_Cnt), 32'(m_redir));
    if (RST) begin
      m_boot = BOOT_CYCLES; m_stall = 0; m_redir = 0;
    end else if (m_boot > 0) begin
      m_boot--;
    end else begin
      if (!e_pc) m_stall = (m_stall + 1) % CNT_MOD;
      if (e_pc && e_sel != 2'b10) m_redir = (m_redir + 1) % CNT_MOD;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_boot();
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < BOOT_CYCLES; i++) cycle();
  endtask

  initial begin
    // Bring counters out of X before the first model comparison.
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    #1;

    // Reset then boot window, then the first fetch.
    cycle();
    chk("rst_pc_en", 32'(s_pc), 32'd0);
    chk("rst_bubble", 32'(s_bub), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("boot_bubble", 32'(s_bub), 32'd1);
    cycle();
    chk("first_fetch_pc_en", 32'(s_pc), 32'd1);
    chk("first_fetch_booting", 32'(s_boot), 32'd0);

    // Redirect pulses.
    set_in(0, 1, 0, 0, 0, 0, 0); cycle();
    chk("br_sel", 32'(s_sel), 32'd1);
    set_in(0, 0, 1, 0, 0, 0, 0); cycle();
    chk("br_cnt", 32'(s_redir), 32'd1);
    chk("j_sel", 32'(s_sel), 32'd3);
    set_in(0, 0, 0, 1, 0, 0, 0); cycle();
    chk("jr_sel", 32'(s_sel), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    chk("redir_cnt3", 32'(s_redir), 32'd3);

    // DC stall held 5 cycles under a pending jump.
    reset_boot();
    set_in(0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle();
    set_in(0, 0, 1, 0, 0, 0, 0); cycle();
    chk("dc_release_sel", 32'(s_sel), 32'd3);
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    chk("dc_stall_cnt", 32'(s_stall), 32'd5);
    chk("dc_redir_cnt", 32'(s_redir), 32'd1);

    // Load-use: single, then back-to-back (redirect flag ignored).
    reset_boot();
    set_in(0, 0, 0, 0, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 1, 0, 0, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    cycle();
    chk("lu_stall_cnt", 32'(s_stall), 32'd3);

    // Reset in the 3rd cycle of an IC stall; stall persists past boot.
    reset_boot();
    set_in(0, 0, 0, 0, 0, 1, 0); cycle(); cycle();
    set_in(1, 0, 0, 0, 0, 1, 0); cycle();
    set_in(0, 0, 0, 0, 0, 1, 0); cycle();
    chk("rst_mid_booting", 32'(s_boot), 32'd1);
    chk("rst_mid_stall_cnt", 32'(s_stall), 32'd0);
    cycle(); cycle();
    chk("post_boot_freeze", 32'(s_pipe), 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();

    // Counter wrap: 17 stall cycles on a 4-bit counter.
    reset_boot();
    set_in(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 17; i++) cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    chk("wrap_stall_cnt", 32'(s_stall), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 49) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
